// File: rtl/pmem_arb_types.sv
// Shared types and sizing for the pmem burst arbiter.
// Optional round-robin tie-break: define PMEM_ARB_RR_EN.
package pmem_arb_types;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/pmem_arbiter_line_burst_adaptor.sv
// Line <-> beat adaptor: beat counter, shared line buffer,
// fourth-beat detect.
module line_burst_adaptor #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              pmem_resp,
  input  logic [BEAT_W-1:0] pmem_rdata,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] wdata,
  output logic              last
);

  localparam int NB = LINE_W / BEAT_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]     beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              step;

  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    step   = (rd_en | wr_en) & pmem_resp;
    last   = step & (beat_q == CW'(NB - 1));
    if (clr) beat_d = '0;
    if (load) line_d = load_line;
    if (step) begin
      // counter wraps to 0 on the final beat
      beat_d = beat_q + 1'b1;
      if (rd_en)
        line_d[int'(beat_q)*BEAT_W +: BEAT_W] = pmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

  assign line  = line_q;
  assign wdata = line_q[int'(beat_q)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/pmem_arbiter.sv
// icache/dcache arbiter onto one pmem burst port.
// PMEM_ARB_RR_EN: round-robin ties; otherwise dcache wins.
module pmem_arbiter #(
  parameter int LINE_W = pmem_arb_types::LINE_W,
  parameter int BEAT_W = pmem_arb_types::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  import pmem_arb_types::*;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        grant, load, last;
  logic        d_req, tie_d, win_d;
  logic        rd_en, wr_en;
  logic [LINE_W-1:0] line;

`ifdef PMEM_ARB_RR_EN
  owner_e ptr_q, ptr_d;
  // pointer names the last served cache; the other wins a tie
  assign tie_d = (ptr_q == OWN_I);
`else
  assign tie_d = 1'b1;
`endif

  assign d_req = d_read | d_write;
  assign win_d = d_req & (~i_read | tie_d);
  assign rd_en = (state_q == I_RD) | (state_q == D_RD);
  assign wr_en = (state_q == D_WR);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    grant      = 1'b0;
    load       = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
`ifdef PMEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_read | d_req) begin
          grant = 1'b1;
          if (win_d) begin
            owner_d = OWN_D;
            addr_d  = d_address & ~32'h1f;
            load    = d_write;
            state_d = d_write ? D_WR : D_RD;
          end else begin
            owner_d = OWN_I;
            addr_d  = i_address & ~32'h1f;
            state_d = I_RD;
          end
`ifdef PMEM_ARB_RR_EN
          ptr_d = owner_d;
`endif
        end
      end
      I_RD, D_RD: begin
        pmem_read = 1'b1;
        if (last) state_d = DONE;
      end
      D_WR: begin
        pmem_write = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        i_resp  = (owner_q == OWN_I);
        d_resp  = (owner_q == OWN_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
`ifdef PMEM_ARB_RR_EN
      ptr_q   <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
`ifdef PMEM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  line_burst_adaptor #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W)
  ) u_adapt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (grant),
    .load      (load),
    .load_line (d_wdata),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .pmem_resp (pmem_resp),
    .pmem_rdata(pmem_rdata),
    .line      (line),
    .wdata     (pmem_wdata),
    .last      (last)
  );

  assign pmem_address = addr_q;
  assign i_rdata      = line;
  assign d_rdata      = line;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter with a transaction-level
// memory/arbitration reference model.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read, d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;
  bit ref_last_d = 1'b0;

  pmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit tie_to_d();
`ifdef PMEM_ARB_RR_EN
    return !ref_last_d;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic serve(input string tag, input bit is_d, input bit is_wr,
                       input logic [31:0] addr, input logic [255:0] wline,
                       input int max_stall, output int lat);
    logic [255:0] rline;
    logic [63:0]  beat;
    int waited;
    rline = '0;
    lat = 0;
    waited = 0;
    while (!(pmem_read | pmem_write) && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    lat = waited;
    check({tag, " grant"}, pmem_read | pmem_write, 1'b1);
    if (!(pmem_read | pmem_write)) return;
    check({tag, " rd"}, pmem_read, !is_wr);
    check({tag, " wr"}, pmem_write, is_wr);
    check({tag, " addr"}, pmem_address, addr & 32'hffff_ffe0);
    ref_last_d = is_d;
    for (int b = 0; b < 4; b++) begin
      int st;
      st = $urandom_range(0, max_stall);
      for (int s = 0; s < st; s++) begin
        pmem_resp = 1'b0;
        @(negedge clk);
        lat++;
        check({tag, " hold"}, pmem_read | pmem_write, 1'b1);
      end
      beat = {$urandom, $urandom};
      pmem_resp  = 1'b1;
      pmem_rdata = beat;
      rline[b*64 +: 64] = beat;
      if (is_wr) check({tag, " wdata"}, pmem_wdata, wline[b*64 +: 64]);
      @(negedge clk);
      lat++;
    end
    pmem_resp = 1'b0;
    check({tag, " idle"}, pmem_read | pmem_write, 1'b0);
    check({tag, " i_resp"}, i_resp, !is_d);
    check({tag, " d_resp"}, d_resp, is_d);
    if (!is_wr) check({tag, " rdata"}, is_d ? d_rdata : i_rdata, rline);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    @(negedge clk);
    check({tag, " resp1"}, {i_resp, d_resp}, 2'b00);
  endtask

  task automatic raise(input bit is_d, input bit is_wr);
    if (is_d) begin
      d_address = $urandom;
      d_wdata   = rand_line();
      d_read    = !is_wr;
      d_write   = is_wr;
    end else begin
      i_address = $urandom;
      i_read    = 1'b1;
    end
  endtask

  initial begin
    int lat;
    bit w_d, w_wr, o_wr;
    rst_n = 1'b0;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = 0; d_address = 0; d_wdata = '0;
    pmem_rdata = 0; pmem_resp = 0;
    #12;
    check("rst pmem_rd", pmem_read, 1'b0);
    check("rst pmem_wr", pmem_write, 1'b0);
    check("rst addr", pmem_address, 32'h0);
    check("rst wdata", pmem_wdata, 64'h0);
    check("rst resp", {i_resp, d_resp}, 2'b00);
    check("rst line", i_rdata, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    i_address = 32'h0000_1040;
    i_read = 1'b1;
    serve("iread", 1'b0, 1'b0, 32'h0000_1040, '0, 0, lat);
    check("iread lat", lat, 5);

    d_address = 32'h8000_0020;
    d_wdata = {64'h3333_3333_cccc_cccc, 64'h2222_2222_bbbb_bbbb,
               64'h1111_1111_aaaa_aaaa, 64'h0000_0000_9999_9999};
    d_write = 1'b1;
    serve("dwrite", 1'b1, 1'b1, 32'h8000_0020, d_wdata, 0, lat);
    check("dwrite lat", lat, 5);

    i_address = 32'h0000_105C;
    i_read = 1'b1;
    serve("unalign", 1'b0, 1'b0, 32'h0000_105C, '0, 3, lat);

    // double contention: winner re-raises right after completion
    raise(1'b0, 1'b0);
    raise(1'b1, 1'b0);
    w_d = tie_to_d();
    serve("tie1", w_d, 1'b0, w_d ? d_address : i_address, '0, 1, lat);
    raise(w_d, 1'b0);
    w_d = tie_to_d();
    serve("tie2", w_d, 1'b0, w_d ? d_address : i_address, '0, 1, lat);
    serve("tie3", !w_d, 1'b0, w_d ? i_address : d_address, '0, 1, lat);

    // reset in the middle of a dcache read
    d_address = 32'h0000_2000;
    d_read = 1'b1;
    @(negedge clk);
    check("abort grant", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    pmem_rdata = 64'h1;
    @(negedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort rd", pmem_read, 1'b0);
    check("abort d_resp", d_resp, 1'b0);
    check("abort addr", pmem_address, 32'h0);
    ref_last_d = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort quiet", {pmem_read, d_resp}, 2'b00);
    i_address = 32'h0000_3000;
    i_read = 1'b1;
    serve("post rst", 1'b0, 1'b0, 32'h0000_3000, '0, 2, lat);

    for (int t = 0; t < 30; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      o_wr = $urandom_range(0, 1) == 1;
      if (kind == 0) begin
        raise(1'b0, 1'b0);
        serve("r_i", 1'b0, 1'b0, i_address, '0, 3, lat);
      end else if (kind == 1) begin
        raise(1'b1, o_wr);
        serve("r_d", 1'b1, o_wr, d_address, d_wdata, 3, lat);
      end else begin
        raise(1'b0, 1'b0);
        raise(1'b1, o_wr);
        w_d = tie_to_d();
        w_wr = w_d & o_wr;
        serve("r_t1", w_d, w_wr, w_d ? d_address : i_address,
              d_wdata, 3, lat);
        serve("r_t2", !w_d, !w_d & o_wr, w_d ? i_address : d_address,
              d_wdata, 3, lat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
